biu_arbiter: RTL and testbench

// - Shares one SDRAM bus interface unit (BIU) between two bus requesters.
// - Round-robin arbitration; the grant is held for the whole BIU transaction.
// - Muxes the granted requester's Addr/Data/Control onto the BIU inputs and pulses En once per transaction.
// - Returns the BIU Ready to the granted requester as a one-cycle Done.
// - Sits between the CPU/DMA masters and biu, which drives CS/RAS/CAS/WE to the SDRAM.

---
 rtl/biu_arbiter.sv | 152 +++++++++++++++
 tb/tb_biu_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/biu_arbiter.sv
// biu_arbiter: two-requester round-robin front end for the SDRAM BIU.
// The winner keeps its grant for the whole BIU transaction. Its address,
// data and control are muxed onto the BIU inputs, and BiuEn pulses once.
// The BIU Ready strobe goes back to the winner as a one-cycle Done.
// Optional feature: define BIU_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
// A timed-out transaction ends with Err[Sel] instead of Done[Sel].
module biu_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int CTRL_W         = 9,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Data0,
  input  logic [CTRL_W-1:0] Ctrl0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data1,
  input  logic [CTRL_W-1:0] Ctrl1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic              Err0,
  output logic              Err1,
  output logic              Busy,
  output logic [ADDR_W-1:0] BiuAddr,
  output logic [DATA_W-1:0] BiuData,
  output logic [CTRL_W-1:0] BiuCtrl,
  output logic              BiuEn,
  input  logic              BiuReady
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // The watchdog needs WAIT to last at least two counts.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("biu_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t state;
  logic   sel;   // requester owning the current transaction
  logic   last;  // requester served most recently
  logic   pick;  // winner if a transaction starts this cycle

  // If both request, the one not served last wins. Otherwise the lone requester wins.
  assign pick = (Req0 && Req1) ? ~last : Req1;

`ifdef BIU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wait_cnt;
  logic             time_up;
  assign time_up = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Arbitration FSM with registered grant, strobe and status outputs.
  // NOTE: all state here uses non-blocking assignments, so every branch reads pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      Gnt0  <= 1'b0;
      Gnt1  <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      Err0  <= 1'b0;
      Err1  <= 1'b0;
      Busy  <= 1'b0;
      BiuEn <= 1'b0;
`ifdef BIU_ARB_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      // Strobes default low, so each one lasts exactly one cycle.
      BiuEn <= 1'b0;
      Done0 <= 1'b0;
      Done1 <= 1'b0;
      Err0  <= 1'b0;
      Err1  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            state <= ISSUE;
            sel   <= pick;
            Gnt0  <= ~pick;
            Gnt1  <= pick;
            Busy  <= 1'b1;
            BiuEn <= 1'b1;
          end
        end
        ISSUE: begin
          // BiuReady is deliberately ignored in this cycle.
          state <= WAIT;
`ifdef BIU_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (BiuReady) begin
            state <= DONE;
            Done0 <= ~sel;
            Done1 <= sel;
`ifdef BIU_ARB_TIMEOUT_EN
          end else if (time_up) begin
            state <= IDLE;
            last  <= sel;
            Gnt0  <= 1'b0;
            Gnt1  <= 1'b0;
            Busy  <= 1'b0;
            Err0  <= ~sel;
            Err1  <= sel;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          last  <= sel;
          Gnt0  <= 1'b0;
          Gnt1  <= 1'b0;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef BIU_ARB_TIMEOUT_EN
  // Without the watchdog, the error flops are never set and synthesise away.
  logic unused_ok;
  assign unused_ok = 1'b0;
`endif

  // Drive the owning requester's fields onto the BIU, or zeros when no one is granted.
  // NOTE: defaults are assigned first so that no path leaves an output unassigned, which would infer a latch.
  always_comb begin
    BiuAddr = '0;
    BiuData = '0;
    BiuCtrl = '0;
    if (Gnt0 || Gnt1) begin
      BiuAddr = sel ? Addr1 : Addr0;
      BiuData = sel ? Data1 : Data0;
      BiuCtrl = sel ? Ctrl1 : Ctrl0;
    end
  end

endmodule

// File: tb/tb_biu_arbiter.sv
// tb_biu_arbiter: directed checks of the BIU arbiter in its default build.
module tb_biu_arbiter;

  localparam logic [31:0] A0 = 32'h0003_1234;
  localparam logic [31:0] A1 = 32'h00AB_CD00;
  localparam logic [31:0] D0 = 32'h1111_2222;
  localparam logic [31:0] D1 = 32'h3333_4444;
  localparam logic [8:0]  C0 = 9'h0A5;
  localparam logic [8:0]  C1 = 9'h15A;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, Req1;
  logic [31:0] Addr0, Addr1, Data0, Data1;
  logic [8:0]  Ctrl0, Ctrl1;
  logic        Gnt0, Gnt1, Done0, Done1, Err0, Err1, Busy, BiuEn, BiuReady;
  logic [31:0] BiuAddr, BiuData;
  logic [8:0]  BiuCtrl;

  int checks = 0;
  int errors = 0;

  biu_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Ctrl0(Ctrl0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Ctrl1(Ctrl1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
    .Err0(Err0), .Err1(Err1), .Busy(Busy),
    .BiuAddr(BiuAddr), .BiuData(BiuData), .BiuCtrl(BiuCtrl),
    .BiuEn(BiuEn), .BiuReady(BiuReady)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle. Inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},  {Gnt0, Gnt1}, 2'b00);
    check({tag, "_done"}, {Done0, Done1}, 2'b00);
    check({tag, "_err"},  {Err0, Err1}, 2'b00);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_en"},   BiuEn, 1'b0);
    check({tag, "_bus"},  {BiuAddr, BiuData, BiuCtrl}, '0);
  endtask

  // One transaction from an IDLE cycle with requests already driven.
  // Ready is raised on the n_wait-th WAIT cycle. The winner's Req drops at Done if drop is set.
  task automatic do_txn(input string tag, input logic exp_sel, input int n_wait, input logic drop);
    logic [31:0] ea, ed;
    logic [8:0]  ec;
    ea = exp_sel ? A1 : A0;
    ed = exp_sel ? D1 : D0;
    ec = exp_sel ? C1 : C0;
    tick();  // ISSUE
    check({tag, "_issue_en"},  BiuEn, 1'b1);
    check({tag, "_issue_gnt"}, {Gnt0, Gnt1}, {~exp_sel, exp_sel});
    check({tag, "_issue_busy"}, Busy, 1'b1);
    check({tag, "_addr"}, BiuAddr, ea);
    check({tag, "_data"}, BiuData, ed);
    check({tag, "_ctrl"}, BiuCtrl, ec);
    tick();  // first WAIT cycle
    check({tag, "_wait_en"}, BiuEn, 1'b0);
    for (int i = 1; i < n_wait; i++) tick();
    check({tag, "_wait_done"}, {Done0, Done1}, 2'b00);
    BiuReady = 1'b1;
    tick();  // DONE
    check({tag, "_done"}, {Done0, Done1}, {~exp_sel, exp_sel});
    check({tag, "_done_gnt"}, {Gnt0, Gnt1}, {~exp_sel, exp_sel});
    BiuReady = 1'b0;
    if (drop) begin
      if (exp_sel) Req1 = 1'b0;
      else         Req0 = 1'b0;
    end
    tick();  // IDLE
    check({tag, "_idle_done"}, {Done0, Done1}, 2'b00);
    check({tag, "_idle_busy"}, Busy, 1'b0);
    check({tag, "_idle_gnt"},  {Gnt0, Gnt1}, 2'b00);
  endtask

  initial begin
    Rst = 1'b1; Req0 = 1'b0; Req1 = 1'b0; BiuReady = 1'b0;
    Addr0 = A0; Data0 = D0; Ctrl0 = C0;
    Addr1 = A1; Data1 = D1; Ctrl1 = C1;
    tick(); tick();
    check_quiet("reset");
    Rst = 1'b0;

    // A single request from 0. Ready comes on the third WAIT cycle.
    Req0 = 1'b1;
    do_txn("single", 1'b0, 3, 1'b1);

    // After a fresh reset both requesters compete, and 0 must win first.
    Rst = 1'b1; tick(); Rst = 1'b0;
    check_quiet("reset2");
    Req0 = 1'b1; Req1 = 1'b1;
    do_txn("cont0", 1'b0, 2, 1'b1);
    do_txn("cont1", 1'b1, 2, 1'b1);

    // Fairness: Req1 stays high and Req0 comes back right after each Done0.
    Req0 = 1'b1; Req1 = 1'b1;
    do_txn("fair_a0", 1'b0, 2, 1'b1);
    Req0 = 1'b1;
    do_txn("fair_b1", 1'b1, 3, 1'b0);
    do_txn("fair_c0", 1'b0, 2, 1'b1);
    Req0 = 1'b1;
    do_txn("fair_d1", 1'b1, 2, 1'b1);
    Req0 = 1'b0;

    // Reset during WAIT aborts the transaction with no Done.
    Req0 = 1'b1;
    tick(); tick(); tick();  // ISSUE, WAIT1, WAIT2
    check("midwait_busy", Busy, 1'b1);
    Rst = 1'b1;
    tick();
    check_quiet("midwait_rst");
    Rst = 1'b0; Req0 = 1'b0;
    tick();
    check_quiet("midwait_after");
    Req1 = 1'b1;
    do_txn("after_rst1", 1'b1, 2, 1'b1);

    // Ready in IDLE and in ISSUE must be ignored. Req dropped in WAIT must still get Done.
    BiuReady = 1'b1;
    tick();
    check_quiet("spur_idle");
    Req0 = 1'b1;
    tick();  // ISSUE, with Ready still high
    check("spur_issue_en", BiuEn, 1'b1);
    tick();  // WAIT1: Ready in ISSUE did not finish the transaction
    check("spur_wait_done", {Done0, Done1}, 2'b00);
    check("spur_wait_busy", Busy, 1'b1);
    BiuReady = 1'b0; Req0 = 1'b0;
    tick();  // WAIT2
    check("drop_wait_gnt", {Gnt0, Gnt1}, 2'b10);
    check("drop_wait_done", {Done0, Done1}, 2'b00);
    BiuReady = 1'b1;
    tick();  // DONE
    check("drop_done", {Done0, Done1}, 2'b10);
    tick();  // IDLE; Ready still high but is ignored in DONE
    check("spur_done_idle", {Done0, Done1, Busy}, 3'b000);
    tick();
    check_quiet("spur_final");
    BiuReady = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
